// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for a single-clock dual-port RAM with a registered head word.
// Optional sticky ovf_o/udf_o error flags are built when DPRAM_FIFO_ERR_EN is defined.
module dpram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic                  wr_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  rd_ready_i,
    output logic                  ram_wr_en_o,
    output logic                  ram_port_en_0_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_0_o,
    output logic [DATA_WIDTH-1:0] ram_data_in_o,
    output logic                  ram_port_en_1_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_1_o,
    input  logic [DATA_WIDTH-1:0] ram_data_out_1_i,
    output logic [ADDR_WIDTH:0]   level_o
`ifdef DPRAM_FIFO_ERR_EN
    ,
    output logic                  ovf_o,
    output logic                  udf_o
`endif
);

    localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [ADDR_WIDTH:0]   level;
    logic                  empty, full, write_fire, load;

    // The wrap bit makes the pointer difference the RAM occupancy directly (0..DEPTH).
    assign level      = wr_ptr_q - rd_ptr_q;
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (level == DEPTH_L);
    assign wr_ready_o = rst_n & ~full;
    assign write_fire = wr_valid_i & wr_ready_o;
    assign load       = ~empty & (~rd_valid_q | rd_ready_i);

    assign ram_wr_en_o     = write_fire;
    assign ram_port_en_0_o = write_fire;
    assign ram_addr_0_o    = wr_ptr_q[ADDR_WIDTH-1:0];
    assign ram_data_in_o   = wr_data_i;
    assign ram_port_en_1_o = ~empty;
    assign ram_addr_1_o    = rd_ptr_q[ADDR_WIDTH-1:0];

    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign level_o    = level;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        if (write_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (load) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_valid_d = 1'b1;
            rd_data_d  = ram_data_out_1_i;
        end else if (rd_valid_q && rd_ready_i) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef DPRAM_FIFO_ERR_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    assign ovf_d = ovf_q | (wr_valid_i & full);
    assign udf_d = udf_q | (rd_ready_i & ~rd_valid_q);
    assign ovf_o = ovf_q;
    assign udf_o = udf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl: behavioural RAM, scoreboard queue of accepted words, directed steps.
// Define DPRAM_FIFO_ERR_EN to also exercise the sticky ovf/udf flags.
module tb_dpram_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic          ram_wr_en, ram_port_en_0, ram_port_en_1;
    logic [AW-1:0] ram_addr_0, ram_addr_1;
    logic [DW-1:0] ram_data_in, ram_data_out_1;
    logic [AW:0]   level;
`ifdef DPRAM_FIFO_ERR_EN
    logic          ovf, udf;
`endif

    int passed = 0;
    int failed = 0;
    int total  = 0;
    int pops   = 0;
    int pushes = 0;
    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] mem[16];

    always #5 clk = ~clk;

    dpram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_valid_i       (wr_valid),
        .wr_data_i        (wr_data),
        .wr_ready_o       (wr_ready),
        .rd_valid_o       (rd_valid),
        .rd_data_o        (rd_data),
        .rd_ready_i       (rd_ready),
        .ram_wr_en_o      (ram_wr_en),
        .ram_port_en_0_o  (ram_port_en_0),
        .ram_addr_0_o     (ram_addr_0),
        .ram_data_in_o    (ram_data_in),
        .ram_port_en_1_o  (ram_port_en_1),
        .ram_addr_1_o     (ram_addr_1),
        .ram_data_out_1_i (ram_data_out_1),
        .level_o          (level)
`ifdef DPRAM_FIFO_ERR_EN
        ,
        .ovf_o            (ovf),
        .udf_o            (udf)
`endif
    );

    always @(posedge clk) begin
        if (ram_wr_en && ram_port_en_0) mem[ram_addr_0] <= ram_data_in;
    end
    assign ram_data_out_1 = ram_port_en_1 ? mem[ram_addr_1] : 'z;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are decided by the state seen at the negedge before the edge that commits them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid && wr_ready) begin
                sb_q.push_back(wr_data);
                pushes++;
            end
            if (rd_valid && rd_ready) begin
                pops++;
                if (sb_q.size() == 0) chk("pop_without_push", 32'(rd_data), 32'hFFFF_FFFF);
                else chk("data_order", 32'(rd_data), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        chk("rst_ram_wr_en", 32'(ram_wr_en), 32'd0);
        chk("rst_wr_ready_low", 32'(wr_ready), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_wr_ready_after", 32'(wr_ready), 32'd1);
        tick();
    endtask

    task automatic drain(input string tag);
        bit done = 1'b0;
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (!rd_valid && level == 0) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(done), 32'd1);
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
        rd_ready = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int d;
        int outs;
        int maxlvl;
        bit saw_full;

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        do_reset();

        // Single word: write at edge k, head valid after edge k+1.
        wr_valid = 1'b1;
        wr_data  = 8'hA5;
        @(negedge clk);
        chk("single_ram_wr_en", 32'(ram_wr_en), 32'd1);
        chk("single_port_en_0", 32'(ram_port_en_0), 32'd1);
        chk("single_addr_0", 32'(ram_addr_0), 32'd0);
        chk("single_data_in", 32'(ram_data_in), 32'hA5);
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("single_k_rd_valid", 32'(rd_valid), 32'd0);
        chk("single_k_level", 32'(level), 32'd1);
        tick();
        @(negedge clk);
        chk("single_k1_rd_valid", 32'(rd_valid), 32'd1);
        chk("single_k1_rd_data", 32'(rd_data), 32'hA5);
        chk("single_k1_level", 32'(level), 32'd0);
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("single_consumed", 32'(rd_valid), 32'd0);
        tick();

        // Fill: 17 words occupy RAM plus output register; the 18th is refused.
        for (int i = 0; i <= 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(i);
            tick();
        end
        wr_data = 8'h11;
        @(negedge clk);
        chk("fill_wr_ready", 32'(wr_ready), 32'd0);
        chk("fill_level", 32'(level), 32'd16);
        chk("fill_no_ram_write", 32'(ram_wr_en), 32'd0);
        tick();
        @(negedge clk);
        chk("fill_level_held", 32'(level), 32'd16);
        wr_valid = 1'b0;
        tick();
        p0 = pops;
        rd_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("fill_resume_ready", 32'(wr_ready), 32'd1);
        chk("fill_resume_level", 32'(level), 32'd15);
        tick();
        drain("fill_drain");
        chk("fill_pop_count", 32'(pops - p0), 32'd17);

        // Streaming: 40 words with both sides always willing.
        p0 = pops;
        d = 0;
        outs = 0;
        maxlvl = 0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            wr_data = 8'(d);
            @(negedge clk);
            if (wr_ready) d++;
            if (rd_valid) outs++;
            if (int'(level) > maxlvl) maxlvl = int'(level);
            tick();
        end
        chk("stream_accepted", 32'(d), 32'd40);
        chk("stream_outputs", 32'(outs), 32'd38);
        chk("stream_max_level", 32'(maxlvl), 32'd1);
        drain("stream_drain");
        chk("stream_pop_count", 32'(pops - p0), 32'd40);

        // Backpressure: consumer takes every other cycle, producer always pushes.
        p0 = pops;
        d = pushes;
        maxlvl = 0;
        saw_full = 1'b0;
        wr_valid = 1'b1;
        for (int c = 0; c < 80; c++) begin
            rd_ready = c[0];
            wr_data  = 8'(c + 8'h40);
            @(negedge clk);
            if (!wr_ready) saw_full = 1'b1;
            if (int'(level) > maxlvl) maxlvl = int'(level);
            tick();
        end
        chk("bp_max_level", 32'(maxlvl), 32'd16);
        chk("bp_saw_not_ready", 32'(saw_full), 32'd1);
        drain("bp_drain");
        chk("bp_in_equals_out", 32'(pops - p0), 32'(pushes - d));

        // Reset mid-stream discards everything in flight.
        wr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 8'(8'hC0 + i);
            tick();
        end
        chk("pre_reset_rd_valid", 32'(rd_valid), 32'd1);
        do_reset();
        @(negedge clk);
        chk("post_reset_level", 32'(level), 32'd0);
        chk("post_reset_port_en_1", 32'(ram_port_en_1), 32'd0);
        tick();

`ifdef DPRAM_FIFO_ERR_EN
        chk("err_ovf_reset", 32'(ovf), 32'd0);
        chk("err_udf_reset", 32'(udf), 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("err_udf_set", 32'(udf), 32'd1);
        chk("err_ovf_clear", 32'(ovf), 32'd0);
        tick();
        for (int i = 0; i <= 16; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(8'h80 + i);
            tick();
        end
        wr_data = 8'h91;
        tick();
        wr_valid = 1'b0;
        @(negedge clk);
        chk("err_ovf_set", 32'(ovf), 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("err_ovf_sticky", 32'(ovf), 32'd1);
        chk("err_udf_sticky", 32'(udf), 32'd1);
        do_reset();
        @(negedge clk);
        chk("err_ovf_cleared", 32'(ovf), 32'd0);
        chk("err_udf_cleared", 32'(udf), 32'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
